phy_mgmt_ctrl: RTL and testbench
================================

# phy_mgmt_ctrl

PHY management controller for the Mimas A7 Ethernet path. It sequences the external PHY's hardware reset, then serves single-register MDIO (IEEE 802.3 clause 22) read/write commands from a local requester over a valid/ready interface. It sits in the `sys_clk` domain beside the RGMII receiver and drives the board's `phy_rst_n`, `mdc` and (through the top-level tristate) `mdio` pins.

## Interface
Parameters:
- `CLK_DIV`, 25: MDC half-period in `sys_clk` cycles (≥2). At 100 MHz this gives 2 MHz MDC.
- `RST_HOLD`, 1_000_000: cycles `phy_rst_n` is held low after reset (≥1).
- `RST_WAIT`, 5_000_000: cycles waited after `phy_rst_n` rises before the first command is accepted (≥1).

Ports:
- `sys_clk` in 1: single clock for the whole block.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accept. A command transfers when `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_phy_addr` in 5: PHYAD.
- `cmd_reg_addr` in 5: REGAD.
- `cmd_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle pulse at command completion (both reads and writes).
- `rsp_rdata` out 16: read data. Held until the next completion. Set to 0 on a write completion.
- `phy_ready` out 1: high once the reset sequence is complete.
- `phy_rst_n` out 1: PHY hardware reset, active-low.
- `mdc` out 1: management clock.
- `mdio_o` out 1: MDIO output value.
- `mdio_oe` out 1: MDIO output enable (1 = drive).
- `mdio_i` in 1: MDIO pin value. Asynchronous; passes through a 2-flop synchronizer.

## Operation
- States: RST_HOLD → RST_WAIT → IDLE → PRE → HDR → TA → DATA → DONE → IDLE.
- RST_HOLD: `phy_rst_n`=0 for `RST_HOLD` cycles, then 1.
- RST_WAIT: count `RST_WAIT` cycles, then assert `phy_ready`=1. It stays 1 until the next reset.
- IDLE: `cmd_ready`=1, `mdc`=0, `mdio_oe`=0.
  - On accept, capture all `cmd_*` fields.
  - `cmd_ready` drops the cycle after accept.
- Bit period = 2·`CLK_DIV` cycles.
  - `mdc`=0 for the first `CLK_DIV` cycles, 1 for the second.
  - `mdio_o`/`mdio_oe` update only on the first cycle of a bit period, i.e. while MDC is low.
  - Bits are sent MSB first.
- PRE: 32 bits of 1, `mdio_oe`=1.
- HDR: 14 bits, driven: ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0].
- TA: 2 bits.
  - Write: drive 1,0.
  - Read: `mdio_oe`=0.
- DATA: 16 bits.
  - Write: drive `cmd_wdata[15:0]`.
  - Read: `mdio_oe`=0. On the last `mdc`=0 cycle of each bit period, sample the synchronized `mdio_i` and shift it in MSB first.
- DONE (one cycle):
  - `mdio_oe`=0, `mdc`=0.
  - `rsp_valid`=1; `rsp_rdata` updated in the same cycle.
  - Next state is IDLE.
- `cmd_valid` before `phy_ready` is ignored (`cmd_ready`=0). The request stays pending and is accepted on the first IDLE cycle.
- No command queueing: exactly one command in flight.

## Timing
- Reset values:
  - `phy_rst_n`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0.
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `phy_ready`=0.
- Reset sequence: `phy_rst_n` rises exactly `RST_HOLD` cycles after `sys_rst` deasserts.
  - `phy_ready` and `cmd_ready` rise `RST_WAIT` cycles after that.
- Frame length is 64 bit periods (32+14+2+16).
  - The first PRE bit starts the cycle after accept.
  - `rsp_valid` pulses the cycle after the last DATA MDC-high half ends.
  - Accept-to-`rsp_valid` = 128·`CLK_DIV` + 1 cycles.
- Back-to-back: `cmd_ready`=1 the cycle after `rsp_valid`. Minimum gap between frames is 2 cycles with MDC low.
- `sys_rst` asserted mid-frame:
  - All outputs go to reset values immediately (asynchronously).
  - The frame is aborted with no `rsp_valid`.
  - The PHY reset sequence restarts.
- Read sample point includes the 2-cycle synchronizer delay. `CLK_DIV`≥2 guarantees the sampled value lies within the current MDC-low half.

## Test plan
- **Reset sequence.** `RST_HOLD`=20, `RST_WAIT`=30, `CLK_DIV`=4. Release `sys_rst` → `phy_rst_n` rises at cycle 20; `phy_ready`/`cmd_ready` rise at cycle 50; `mdc` stays 0 throughout.
- **Write.** PHYAD=0x01, REGAD=0x00, data 0x1140 → the MDIO bitstream on MDC rising edges is 32×1, 0101, 00001, 00000, 10, 0001000101000000. `rsp_valid` arrives 513 cycles after accept with `rsp_rdata`=0.
- **Read.** PHYAD=0x03, REGAD=0x02; PHY model drives 0xBEEF during DATA → `mdio_oe`=0 from TA onward, OP bits are 10, and `rsp_rdata`=0xBEEF with `rsp_valid` pulsing once.
- **Early and back-to-back commands.**
  - `cmd_valid` held from reset release → accepted only when `phy_ready`=1.
  - A second read issued immediately after completion → accepted the cycle after `rsp_valid`, with the second frame's data correct.
- **Reset mid-frame.** Assert `sys_rst` during HDR of a write → `mdio_oe`=0, `phy_rst_n`=0 and `cmd_ready`=0 immediately; no `rsp_valid`; the full reset sequence repeats after release.

Source files
------------

// File: rtl/phy_mgmt_ctrl.sv
// PHY management: sequences the PHY hardware reset, then runs one clause-22 MDIO frame per accepted command.
// Accept to rsp_valid is 128*CLK_DIV+1 cycles; cmd_ready stays low from accept until the cycle after rsp_valid.
module phy_mgmt_ctrl #(
  parameter int CLK_DIV  = 25,
  parameter int RST_HOLD = 1_000_000,
  parameter int RST_WAIT = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        phy_ready,
  output logic        phy_rst_n,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_RST_HOLD, S_RST_WAIT, S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [31:0]   rst_cnt, next_rst_cnt;
  logic [PW-1:0] ph, next_ph;
  logic [5:0]    bit_cnt, next_bit_cnt;
  logic          bit_end, frame_next;
  logic [31:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic          op_write;
  logic          mdio_meta, mdio_sync;

  function automatic logic in_frame(input state_t s);
    return (s == S_PRE) || (s == S_HDR) || (s == S_TA) || (s == S_DATA);
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= S_RST_HOLD;
      rst_cnt <= '0;
      ph      <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      rst_cnt <= next_rst_cnt;
      ph      <= next_ph;
      bit_cnt <= next_bit_cnt;
    end
  end

  always_comb begin
    next_state   = state;
    bit_end      = (ph == PH_LAST);
    case (state)
      S_RST_HOLD: if (rst_cnt == 32'(RST_HOLD - 1)) next_state = S_RST_WAIT;
      S_RST_WAIT: if (rst_cnt == 32'(RST_WAIT - 1)) next_state = S_IDLE;
      S_IDLE:     if (cmd_valid) next_state = S_PRE;
      S_PRE:      if (bit_end && bit_cnt == 6'd31) next_state = S_HDR;
      S_HDR:      if (bit_end && bit_cnt == 6'd13) next_state = S_TA;
      S_TA:       if (bit_end && bit_cnt == 6'd1)  next_state = S_DATA;
      S_DATA:     if (bit_end && bit_cnt == 6'd15) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_RST_HOLD;
    endcase

    next_rst_cnt = '0;
    if (next_state == state && (state == S_RST_HOLD || state == S_RST_WAIT))
      next_rst_cnt = rst_cnt + 32'd1;

    // Phase and per-state bit counters restart whenever the frame section changes.
    frame_next   = in_frame(next_state);
    next_ph      = '0;
    next_bit_cnt = '0;
    if (frame_next && in_frame(state)) begin
      next_ph = bit_end ? '0 : ph + PW'(1);
      if (!bit_end)
        next_bit_cnt = bit_cnt;
      else if (next_state == state)
        next_bit_cnt = bit_cnt + 6'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      mdio_meta <= mdio_i;
      mdio_sync <= mdio_meta;
    end
  end

  // Pin outputs are registered from next-state values so mdc cannot glitch.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phy_rst_n <= 1'b0;
      phy_ready <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_rdata <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      op_write  <= 1'b0;
    end else begin
      if (state == S_RST_HOLD && next_state == S_RST_WAIT) phy_rst_n <= 1'b1;
      if (state == S_RST_WAIT && next_state == S_IDLE)     phy_ready <= 1'b1;

      mdc <= frame_next && (next_ph >= PH_HALF);

      if (state == S_IDLE && next_state == S_PRE) begin
        tx_sr    <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                     2'b10, cmd_wdata};
        rx_sr    <= '0;
        op_write <= cmd_write;
      end

      if (!frame_next) begin
        mdio_oe <= 1'b0;
        mdio_o  <= 1'b1;
      end else if (next_ph == '0) begin
        case (next_state)
          S_PRE: begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b1;
          end
          S_HDR: begin
            mdio_oe <= 1'b1;
            mdio_o  <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
          end
          default: begin
            mdio_oe <= op_write;
            mdio_o  <= op_write ? tx_sr[31] : 1'b1;
            tx_sr   <= {tx_sr[30:0], 1'b0};
          end
        endcase
      end

      if (state == S_DATA && !op_write && ph == PH_SAMPLE)
        rx_sr <= {rx_sr[14:0], mdio_sync};

      if (state == S_DATA && next_state == S_DONE)
        rsp_rdata <= op_write ? 16'h0000 : rx_sr;
    end
  end

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Bench for phy_mgmt_ctrl: reset sequencing, directed and random MDIO frames against a frame-level
// reference model and a simple PHY read responder, back-to-back commands and reset mid-frame.
module tb_phy_mgmt_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int RST_HOLD = 20;
  localparam int RST_WAIT = 30;
  localparam int LAT      = 128 * CLK_DIV + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        phy_ready, phy_rst_n, mdc, mdio_o, mdio_oe;
  logic        mdio_i = 1'b1;

  int total = 0, bad = 0;
  int cyc = 0, rsp_cnt = 0, n_done = 0, n_edge = 0;
  int acc_cyc = 0, last_rsp_cyc = 0, rst_end_cyc = 0;
  logic cap_o[$], cap_oe[$];
  bit          phy_drive = 1'b0;
  logic [15:0] phy_data  = '0;

  bit          wr;
  logic [4:0]  pa, ra;
  logic [15:0] wd, rd;
  bit          hdr_ok;

  phy_mgmt_ctrl #(.CLK_DIV(CLK_DIV), .RST_HOLD(RST_HOLD), .RST_WAIT(RST_WAIT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .phy_ready(phy_ready),
    .phy_rst_n(phy_rst_n), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
    #2;
    if (rsp_valid) rsp_cnt++;
  end

  // Captures the line on each MDC rise; as the PHY, drives read data after rises 47..62.
  initial forever begin
    @(posedge mdc);
    #1;
    cap_o.push_back(mdio_o);
    cap_oe.push_back(mdio_oe);
    if (phy_drive && n_edge >= 47 && n_edge <= 62) mdio_i = phy_data[62 - n_edge];
    else mdio_i = 1'b1;
    n_edge++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst_seq();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int k = 1; k <= RST_HOLD + RST_WAIT; k++) begin
      @(negedge sys_clk);
      chk("rst_seq_phy_rst_n", 64'(phy_rst_n), 64'(k >= RST_HOLD));
      chk("rst_seq_phy_ready", 64'(phy_ready), 64'(k >= RST_HOLD + RST_WAIT));
      chk("rst_seq_cmd_ready", 64'(cmd_ready), 64'(k >= RST_HOLD + RST_WAIT));
      chk("rst_seq_mdc",       64'(mdc),       64'(0));
    end
    rst_end_cyc = cyc;
  endtask

  task automatic send_cmd(input bit w, input logic [4:0] p, input logic [4:0] r,
                          input logic [15:0] d, input logic [15:0] phy_rd, input bit b2b);
    bit ok;
    cmd_write = w; cmd_phy_addr = p; cmd_reg_addr = r; cmd_wdata = d; cmd_valid = 1'b1;
    phy_drive = !w; phy_data = phy_rd;
    cap_o.delete(); cap_oe.delete(); n_edge = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("accept_seen", 64'(ok), 64'(1));
    acc_cyc = cyc;
    chk("idle_mdc", 64'(mdc), 64'(0));
    chk("idle_mdio_oe", 64'(mdio_oe), 64'(0));
    chk("rsp_count_at_accept", 64'(rsp_cnt), 64'(n_done));
    if (b2b) chk("b2b_accept_gap", 64'(acc_cyc - last_rsp_cyc), 64'(1));
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("ready_drop_after_accept", 64'(cmd_ready), 64'(0));
  endtask

  task automatic finish_cmd(input bit w, input logic [4:0] p, input logic [4:0] r,
                            input logic [15:0] d, input logic [15:0] phy_rd);
    bit ok;
    logic [63:0] got_o, got_oe, exp_o, exp_oe;
    ok = 1'b0;
    for (int i = 0; i < LAT + 50; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("rsp_seen", 64'(ok), 64'(1));
    last_rsp_cyc = cyc;
    chk("rsp_latency", 64'(last_rsp_cyc - acc_cyc), 64'(LAT));
    chk("rsp_rdata", 64'(rsp_rdata), w ? 64'(0) : 64'(phy_rd));
    chk("done_mdc", 64'(mdc), 64'(0));
    chk("done_mdio_oe", 64'(mdio_oe), 64'(0));
    n_done++;

    // Reference frame: 32 preamble ones, ST, OP, PHYAD, REGAD, TA, DATA; reads release the line after REGAD.
    exp_o  = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), p, r, 2'b10, d};
    exp_oe = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
    got_o = '0;
    got_oe = '0;
    for (int i = 0; i < cap_o.size() && i < 64; i++) begin
      got_o[63 - i]  = cap_o[i];
      got_oe[63 - i] = cap_oe[i];
    end
    chk("frame_mdc_rises", 64'(cap_o.size()), 64'(64));
    chk("frame_mdio_oe", got_oe, exp_oe);
    chk("frame_mdio_o", got_o & exp_oe, exp_o & exp_oe);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy_addr = '0; cmd_reg_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge sys_clk);
    chk("reset_phy_rst_n", 64'(phy_rst_n), 64'(0));
    chk("reset_mdc",       64'(mdc),       64'(0));
    chk("reset_mdio_o",    64'(mdio_o),    64'(1));
    chk("reset_mdio_oe",   64'(mdio_oe),   64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_phy_ready", 64'(phy_ready), 64'(0));

    // Directed write, requested before the PHY is ready.
    cmd_write = 1'b1; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h00; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    check_rst_seq();
    send_cmd(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0);
    chk("early_cmd_accept_cycle", 64'(acc_cyc), 64'(rst_end_cyc));
    finish_cmd(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000);

    // Directed read, then a second read issued straight after completion.
    send_cmd(1'b0, 5'h03, 5'h02, 16'h0000, 16'hBEEF, 1'b1);
    finish_cmd(1'b0, 5'h03, 5'h02, 16'h0000, 16'hBEEF);
    rd = 16'($urandom);
    send_cmd(1'b0, 5'h1F, 5'h11, 16'h0000, rd, 1'b1);
    finish_cmd(1'b0, 5'h1F, 5'h11, 16'h0000, rd);

    for (int n = 0; n < 6; n++) begin
      wr = 1'($urandom_range(0, 1));
      pa = 5'($urandom); ra = 5'($urandom);
      wd = 16'($urandom); rd = 16'($urandom);
      send_cmd(wr, pa, ra, wd, rd, 1'b1);
      finish_cmd(wr, pa, ra, wd, rd);
    end

    // Reset asserted while the header of a write is on the wire.
    pa = 5'($urandom); ra = 5'($urandom); wd = 16'($urandom);
    send_cmd(1'b1, pa, ra, wd, 16'h0000, 1'b1);
    hdr_ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_edge >= 36) begin hdr_ok = 1'b1; break; end
      @(negedge sys_clk);
    end
    chk("hdr_reached", 64'(hdr_ok), 64'(1));
    chk("hdr_mdio_oe_driving", 64'(mdio_oe), 64'(1));
    #2 sys_rst = 1'b1;
    #1;
    chk("abort_mdio_oe",   64'(mdio_oe),   64'(0));
    chk("abort_mdio_o",    64'(mdio_o),    64'(1));
    chk("abort_phy_rst_n", 64'(phy_rst_n), 64'(0));
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("abort_phy_ready", 64'(phy_ready), 64'(0));
    chk("abort_mdc",       64'(mdc),       64'(0));
    repeat (3) @(negedge sys_clk);
    check_rst_seq();
    chk("no_rsp_after_abort", 64'(rsp_cnt), 64'(n_done));

    pa = 5'($urandom); ra = 5'($urandom); rd = 16'($urandom);
    send_cmd(1'b0, pa, ra, 16'h0000, rd, 1'b0);
    finish_cmd(1'b0, pa, ra, 16'h0000, rd);
    repeat (2) @(negedge sys_clk);
    chk("final_rsp_count", 64'(rsp_cnt), 64'(n_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
